// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-ported word memory between fetch and load/store,
// one transaction in flight, fixed read latency, misaligned accesses answered with an error and no access.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_d_q, last_d_d;
    logic              own_d_q, own_d_d;
    logic              wr_q, wr_d;
    logic              mis_q, mis_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_d, grant_if, done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            last_d_q <= 1'b0;
            own_d_q  <= 1'b0;
            wr_q     <= 1'b0;
            mis_q    <= 1'b0;
            first_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            own_d_q  <= own_d_d;
            wr_q     <= wr_d;
            mis_q    <= mis_d;
            first_q  <= first_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // last_d_q=0 after reset means fetch was last owner, so data wins the first tie
    assign grant_d  = (state_q == IDLE) && d_req && (!if_req || !last_d_q);
    assign grant_if = (state_q == IDLE) && if_req && !grant_d;
    assign done     = (state_q == ACCESS) && (mis_q || cnt_q == 3'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        own_d_d  = own_d_q;
        wr_d     = wr_q;
        mis_d    = mis_q;
        first_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (grant_d || grant_if) begin
            state_d  = ACCESS;
            cnt_d    = 3'(MEM_LAT);
            last_d_d = grant_d;
            own_d_d  = grant_d;
            wr_d     = grant_d && d_wr;
            addr_d   = grant_d ? d_addr : if_addr;
            mis_d    = grant_d ? |d_addr[1:0] : |if_addr[1:0];
            wdata_d  = grant_d ? d_wdata : '0;
            first_d  = 1'b1;
        end else if (state_q == ACCESS) begin
            cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
            state_d = done ? IDLE : ACCESS;
        end
    end

    always_comb begin
        if_gnt     = grant_if;
        d_gnt      = grant_d;
        mem_enable = first_q && !mis_q;
        mem_wr     = first_q && !mis_q && wr_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        if_rvalid  = done && !own_d_q;
        d_rvalid   = done && own_d_q;
        d_err      = done && mis_q;
        if_rdata   = (done && !own_d_q && !mis_q) ? mem_rdata : '0;
        d_rdata    = (done && own_d_q && !mis_q && !wr_q) ? mem_rdata : '0;
        busy       = state_q == ACCESS;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors on three arbiter instances (MEM_LAT 1, 3, 0),
// each held in reset while another is exercised.
module tb_mem_port_arbiter;
    logic        clk;
    logic [2:0]  rst_v;
    logic        if_req, d_req, d_wr;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  if_gnt_w, if_rvalid_w, d_gnt_w, d_rvalid_w, d_err_w, mem_enable_w, mem_wr_w, busy_w;
    logic [31:0] if_rdata_w [3];
    logic [31:0] d_rdata_w [3];
    logic [31:0] mem_addr_w [3];
    logic [31:0] mem_wdata_w [3];
    logic [31:0] mem_rdata_w [3];
    logic [31:0] mem [16];
    logic [31:0] rd0;
    int checks = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : gi
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : (g == 1 ? 3 : 0))) dut (
            .clk(clk), .rst(rst_v[g]),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[g]),
            .if_rvalid(if_rvalid_w[g]), .if_rdata(if_rdata_w[g]),
            .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
            .d_gnt(d_gnt_w[g]), .d_rvalid(d_rvalid_w[g]), .d_rdata(d_rdata_w[g]), .d_err(d_err_w[g]),
            .mem_enable(mem_enable_w[g]), .mem_wr(mem_wr_w[g]), .mem_addr(mem_addr_w[g]),
            .mem_wdata(mem_wdata_w[g]), .mem_rdata(mem_rdata_w[g]), .busy(busy_w[g])
        );
        if (g == 0) begin : gm
            assign mem_rdata_w[g] = rd0;
        end else begin : gp
            assign mem_rdata_w[g] = 32'h5A00_0000 ^ mem_addr_w[g];
        end
    end

    // one-cycle read latency word memory for the MEM_LAT=1 instance
    always @(posedge clk) begin
        if (rst_v[0]) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
            rd0 <= 32'h0;
        end else if (mem_enable_w[0]) begin
            if (mem_wr_w[0]) mem[mem_addr_w[0][5:2]] <= mem_wdata_w[0];
            else rd0 <= mem[mem_addr_w[0][5:2]];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        dw;
        logic [31:0] dd;
        logic [7:0]  ctl;
        logic [31:0] ird;
        logic [31:0] drd;
        logic [31:0] ma;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic [31:0] da, logic dw,
                                logic [31:0] dd, logic [7:0] ctl, logic [31:0] ird, logic [31:0] drd,
                                logic [31:0] ma);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dw = dw; v.dd = dd;
        v.ctl = ctl; v.ird = ird; v.drd = drd; v.ma = ma;
        return v;
    endfunction

    // {if_gnt, d_gnt, if_rvalid, d_rvalid, d_err, mem_enable, mem_wr, busy}
    function automatic logic [7:0] ctl(int g);
        return {if_gnt_w[g], d_gnt_w[g], if_rvalid_w[g], d_rvalid_w[g], d_err_w[g],
                mem_enable_w[g], mem_wr_w[g], busy_w[g]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic ir, logic [31:0] ia, logic dr, logic [31:0] da, logic dw, logic [31:0] dd);
        if_req = ir; if_addr = ia; d_req = dr; d_addr = da; d_wr = dw; d_wdata = dd;
    endtask

    initial begin
        int lat;
        logic [31:0] got;
        rst_v = 3'b111;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[0]  = mk(1'b1, 32'h10, 1'b0, 32'h0,  1'b0, 32'h0,        8'b1000_0000, 32'h0,         32'h0,         32'h0);
        tbl[1]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0000_0101, 32'h0,         32'h0,         32'h10);
        tbl[2]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0010_0001, 32'hC0DE_0004, 32'h0,         32'h0);
        tbl[3]  = mk(1'b0, 32'h0,  1'b1, 32'h20, 1'b1, 32'hDEADBEEF, 8'b0100_0000, 32'h0,         32'h0,         32'h0);
        tbl[4]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0000_0111, 32'h0,         32'h0,         32'h20);
        tbl[5]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0001_0001, 32'h0,         32'h0,         32'h0);
        tbl[6]  = mk(1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 32'h0,        8'b0100_0000, 32'h0,         32'h0,         32'h0);
        tbl[7]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0000_0101, 32'h0,         32'h0,         32'h20);
        tbl[8]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0001_0001, 32'h0,         32'hDEADBEEF,  32'h0);
        tbl[9]  = mk(1'b0, 32'h0,  1'b1, 32'h22, 1'b0, 32'h0,        8'b0100_0000, 32'h0,         32'h0,         32'h0);
        tbl[10] = mk(1'b0, 32'h0,  1'b1, 32'h24, 1'b0, 32'h0,        8'b0001_1001, 32'h0,         32'h0,         32'h0);
        tbl[11] = mk(1'b0, 32'h0,  1'b1, 32'h24, 1'b0, 32'h0,        8'b0100_0000, 32'h0,         32'h0,         32'h0);
        tbl[12] = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0000_0101, 32'h0,         32'h0,         32'h24);
        tbl[13] = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0001_0001, 32'h0,         32'hC0DE_0009, 32'h0);
        tbl[14] = mk(1'b1, 32'h0,  1'b1, 32'h4,  1'b0, 32'h0,        8'b1000_0000, 32'h0,         32'h0,         32'h0);
        tbl[15] = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0000_0101, 32'h0,         32'h0,         32'h0);
        tbl[16] = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0010_0001, 32'hC0DE_0000, 32'h0,         32'h0);
        tbl[17] = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        8'b0000_0000, 32'h0,         32'h0,         32'h0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", 32'(ctl(0)), 32'h0);
        chk("reset_maddr", mem_addr_w[0], 32'h0);
        @(negedge clk);
        rst_v[0] = 1'b0;

        // single fetch, store/load round trip, misaligned, back-to-back, tie after data
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].da, tbl[i].dw, tbl[i].dd);
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl(0)), 32'(tbl[i].ctl));
            chk($sformatf("vec%0d_if_rdata", i), if_rdata_w[0], tbl[i].ird);
            chk($sformatf("vec%0d_d_rdata", i), d_rdata_w[0], tbl[i].drd);
            if (tbl[i].ctl[2]) chk($sformatf("vec%0d_mem_addr", i), mem_addr_w[0], tbl[i].ma);
        end

        // both requesting from reset: D, IF, D, IF every MEM_LAT+2 cycles
        @(negedge clk);
        rst_v[0] = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst_v[0] = 1'b0;
        drive(1'b1, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("alt%0d_gnt", k), 32'({if_gnt_w[0], d_gnt_w[0]}),
                (k % 3 != 0) ? 32'd0 : (((k / 3) % 2 == 0) ? 32'd1 : 32'd2));
        end

        // MEM_LAT=3: reset in C+2 discards the in-flight fetch
        @(negedge clk);
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b0;
        drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("lat3_gnt", 32'(ctl(1)), 32'h80);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("lat3_access", 32'(ctl(1)), 32'h05);
        @(negedge clk);
        rst_v[1] = 1'b1;
        #1;
        chk("lat3_rst_busy", 32'(busy_w[1]), 32'h0);
        @(negedge clk);
        rst_v[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lat3_quiet%0d", k), 32'(ctl(1)), 32'h0);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 32'hC, 1'b0, 32'h0);
        #1;
        chk("lat3_d_gnt", 32'(ctl(1)), 32'h40);
        lat = -1;
        got = 32'h0;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            #1;
            if (d_rvalid_w[1]) begin
                lat = n;
                got = d_rdata_w[1];
            end
        end
        chk("lat3_resp_cycle", 32'(lat), 32'd4);
        chk("lat3_rdata", got, 32'h5A00_000C);

        // MEM_LAT=0: response in the enable cycle, one fetch every two cycles
        @(negedge clk);
        rst_v[1] = 1'b1;
        rst_v[2] = 1'b0;
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("lat0_%0d_ctl", k), 32'(ctl(2)), (k % 2 == 0) ? 32'h80 : 32'h25);
            chk($sformatf("lat0_%0d_rdata", k), if_rdata_w[2], (k % 2 == 0) ? 32'h0 : 32'h5A00_0040);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
